// File: rtl/invader_formation_pkg.sv
// Shared constants and state encoding for the invader formation and the VGA controller.
// Optional build macro: INVADER_SPEEDUP_EN (shortens the march period as invaders die).
package invader_formation_pkg;

    localparam int INVADERS_H   = 11;
    localparam int INVADERS_V   = 5;
    localparam int NUM_INVADERS = INVADERS_H * INVADERS_V;
    localparam int COL_PITCH    = 16;
    localparam int ROW_PITCH    = 16;
    localparam int SPRITE_W     = 12;
    localparam int SPRITE_H     = 8;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int X_MIN        = 8;
    localparam int X_MAX        = 632;
    localparam int Y_LAND       = 440;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        CLEARED = 2'd2,
        LANDED  = 2'd3
    } formState_e;

    // Alive-mask bit position of an invader; row 0 occupies the low bits.
    function automatic int bitIndex(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/invader_formation_extents.sv
// Combinational live extents of the alive mask: leftmost/rightmost live column,
// lowest live row, and a flag that the mask is non-empty.
module formation_extents
    import invader_formation_pkg::*;
#(
    parameter int COLS = INVADERS_H,
    parameter int ROWS = INVADERS_V,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic [COLS*ROWS-1:0] mask,
    output logic [COL_W-1:0]     lcol,
    output logic [COL_W-1:0]     rcol,
    output logic [ROW_W-1:0]     brow,
    output logic                 valid
);

    logic [COLS-1:0] colAny;
    logic [ROWS-1:0] rowAny;

    always_comb begin
        colAny = '0;
        rowAny = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mask[bitIndex(r, c, COLS)]) begin
                    colAny[c] = 1'b1;
                    rowAny[r] = 1'b1;
                end
            end
        end
    end

    // Later loop iterations overwrite earlier ones, so scan direction picks the extreme.
    always_comb begin
        lcol = '0;
        rcol = '0;
        brow = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (colAny[c]) lcol = COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (colAny[c]) rcol = COL_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (rowAny[r]) brow = ROW_W'(r);
        end
    end

    assign valid = |mask;

endmodule

// File: rtl/invader_formation.sv
// Invader grid state for one wave: alive mask, formation origin and march/descend motion.
// Optional build macro: INVADER_SPEEDUP_EN (period = min(BASE_PERIOD, alive/4 + 1)).
module invader_formation #(
    parameter int INVADERS_H  = invader_formation_pkg::INVADERS_H,
    parameter int INVADERS_V  = invader_formation_pkg::INVADERS_V,
    parameter int COL_PITCH   = invader_formation_pkg::COL_PITCH,
    parameter int ROW_PITCH   = invader_formation_pkg::ROW_PITCH,
    parameter int SPRITE_W    = invader_formation_pkg::SPRITE_W,
    parameter int SPRITE_H    = invader_formation_pkg::SPRITE_H,
    parameter int START_X     = 40,
    parameter int START_Y     = 48,
    parameter int X_MIN       = invader_formation_pkg::X_MIN,
    parameter int X_MAX       = invader_formation_pkg::X_MAX,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 8,
    parameter int Y_LAND      = invader_formation_pkg::Y_LAND,
    parameter int BASE_PERIOD = 16
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           frame,
    input  logic                           start,
    input  logic                           hit_valid,
    input  logic [2:0]                     hit_row,
    input  logic [3:0]                     hit_col,
    output logic [INVADERS_H*INVADERS_V-1:0] invaders,
    output logic [9:0]                     invaders_x,
    output logic [9:0]                     invaders_y,
    output logic [5:0]                     alive_count,
    output logic                           wave_clear,
    output logic                           landed
);

    import invader_formation_pkg::*;

    localparam int N     = INVADERS_H * INVADERS_V;
    localparam int CNT_W = $clog2(BASE_PERIOD + 1);
    localparam int IDX_W = $clog2(N);
    localparam int COL_W = $clog2(INVADERS_H);
    localparam int ROW_W = $clog2(INVADERS_V);

    formState_e       state_q, state_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [9:0]       xPos_q, xPos_d;
    logic [9:0]       yPos_q, yPos_d;
    logic             moveRight_q, moveRight_d;
    logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
    logic [5:0]       aliveCnt_q, aliveCnt_d;
    logic             waveClear_q, waveClear_d;
    logic             landed_q, landed_d;

    logic [COL_W-1:0] lcol, rcol;
    logic [ROW_W-1:0] brow;
    logic             extValid;

    formation_extents #(
        .COLS (INVADERS_H),
        .ROWS (INVADERS_V)
    ) uExtents (
        .mask  (mask_q),
        .lcol  (lcol),
        .rcol  (rcol),
        .brow  (brow),
        .valid (extValid)
    );

    logic [CNT_W-1:0] period;
`ifdef INVADER_SPEEDUP_EN
    logic [5:0] fastPeriod;
    assign fastPeriod = (aliveCnt_q >> 2) + 6'd1;
    assign period     = (int'(fastPeriod) < BASE_PERIOD) ? CNT_W'(fastPeriod) : CNT_W'(BASE_PERIOD);
`else
    assign period     = CNT_W'(BASE_PERIOD);
`endif

    // ">=" rather than "==" so a period that shrinks below the running count still steps.
    logic [CNT_W:0] cntPlus;
    logic           stepDue;
    assign cntPlus = {1'b0, frameCnt_q} + (CNT_W + 1)'(1);
    assign stepDue = frame && (cntPlus >= {1'b0, period}) && extValid;

    logic [10:0] rightEdge, leftEdge, landEdge;
    logic        blocked, landNow;
    logic [9:0]  xStepped, yStepped;

    // Bound checks use 11 bits so a formation near the screen edge cannot wrap.
    assign rightEdge = {1'b0, xPos_q} + 11'(rcol) * 11'(COL_PITCH) + 11'(SPRITE_W + STEP_X);
    assign leftEdge  = {1'b0, xPos_q} + 11'(lcol) * 11'(COL_PITCH);
    assign blocked   = moveRight_q ? (rightEdge > 11'(X_MAX)) : (leftEdge < 11'(X_MIN + STEP_X));
    assign xStepped  = blocked ? xPos_q
                     : (moveRight_q ? xPos_q + 10'(STEP_X) : xPos_q - 10'(STEP_X));
    assign yStepped  = blocked ? yPos_q + 10'(STEP_Y) : yPos_q;
    assign landEdge  = {1'b0, yStepped} + 11'(brow) * 11'(ROW_PITCH) + 11'(SPRITE_H);
    assign landNow   = landEdge >= 11'(Y_LAND);

    logic             hitInRange, hitAccept;
    logic [IDX_W-1:0] hitIdx;
    logic [N-1:0]     hitOneHot;

    assign hitInRange = (int'(hit_row) < INVADERS_V) && (int'(hit_col) < INVADERS_H);
    assign hitIdx     = IDX_W'(int'(hit_row) * INVADERS_H + int'(hit_col));

    always_comb begin
        hitOneHot = '0;
        if (hitInRange) hitOneHot[hitIdx] = 1'b1;
    end

    assign hitAccept = hit_valid && (state_q == MARCH) && (|(mask_q & hitOneHot));

    // Next-state: step and hit apply independently; clearing the wave outranks landing.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        xPos_d      = xPos_q;
        yPos_d      = yPos_q;
        moveRight_d = moveRight_q;
        frameCnt_d  = frameCnt_q;
        aliveCnt_d  = aliveCnt_q;
        waveClear_d = 1'b0;

        case (state_q)
            MARCH: begin
                if (stepDue) begin
                    frameCnt_d = '0;
                    xPos_d     = xStepped;
                    yPos_d     = yStepped;
                    if (blocked) moveRight_d = ~moveRight_q;
                    if (landNow) state_d = LANDED;
                end else if (frame) begin
                    frameCnt_d = frameCnt_q + CNT_W'(1);
                end

                if (hitAccept) begin
                    mask_d     = mask_q & ~hitOneHot;
                    aliveCnt_d = aliveCnt_q - 6'd1;
                    if (aliveCnt_q == 6'd1) begin
                        waveClear_d = 1'b1;
                        state_d     = CLEARED;
                    end
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d     = MARCH;
            mask_d      = '1;
            xPos_d      = 10'(START_X);
            yPos_d      = 10'(START_Y);
            moveRight_d = 1'b1;
            frameCnt_d  = '0;
            aliveCnt_d  = 6'(N);
            waveClear_d = 1'b0;
        end

        landed_d = (state_d == LANDED);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            xPos_q      <= 10'(START_X);
            yPos_q      <= 10'(START_Y);
            moveRight_q <= 1'b1;
            frameCnt_q  <= '0;
            aliveCnt_q  <= '0;
            waveClear_q <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            xPos_q      <= xPos_d;
            yPos_q      <= yPos_d;
            moveRight_q <= moveRight_d;
            frameCnt_q  <= frameCnt_d;
            aliveCnt_q  <= aliveCnt_d;
            waveClear_q <= waveClear_d;
            landed_q    <= landed_d;
        end
    end

    assign invaders    = mask_q;
    assign invaders_x  = xPos_q;
    assign invaders_y  = yPos_q;
    assign alive_count = aliveCnt_q;
    assign wave_clear  = waveClear_q;
    assign landed      = landed_q;

endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation: reset, marching, hits, wave clear and landing.
module tb_invader_formation;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        frame, start, start2, hit_valid;
    logic [2:0]  hit_row;
    logic [3:0]  hit_col;

    logic [54:0] invaders, invaders2;
    logic [9:0]  invX, invY, invX2, invY2;
    logic [5:0]  alive, alive2;
    logic        waveClear, waveClear2, landed, landed2;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    localparam logic [54:0] ALL_ONES = {55{1'b1}};

    always #5 clk = ~clk;

    invader_formation dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .frame       (frame),
        .start       (start),
        .hit_valid   (hit_valid),
        .hit_row     (hit_row),
        .hit_col     (hit_col),
        .invaders    (invaders),
        .invaders_x  (invX),
        .invaders_y  (invY),
        .alive_count (alive),
        .wave_clear  (waveClear),
        .landed      (landed)
    );

    // Second instance starts low and near the right bound so one descend lands it.
    invader_formation #(
        .START_X (460),
        .START_Y (424)
    ) dutLand (
        .clk         (clk),
        .arst_n      (arst_n),
        .frame       (frame),
        .start       (start2),
        .hit_valid   (hit_valid),
        .hit_row     (hit_row),
        .hit_col     (hit_col),
        .invaders    (invaders2),
        .invaders_x  (invX2),
        .invaders_y  (invY2),
        .alive_count (alive2),
        .wave_clear  (waveClear2),
        .landed      (landed2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int nSteps);
        repeat (nSteps * 16) begin
            frame = 1'b1;
            cycle();
            frame = 1'b0;
            cycle();
        end
    endtask

    task automatic applyFrames(input int n);
        repeat (n) begin
            frame = 1'b1;
            cycle();
            frame = 1'b0;
            cycle();
        end
    endtask

    task automatic applyHit(input int r, input int c);
        hit_row   = 3'(r);
        hit_col   = 4'(c);
        hit_valid = 1'b1;
        cycle();
        hit_valid = 1'b0;
    endtask

    logic [54:0] expMask;

    initial begin
        arst_n    = 1'b0;
        frame     = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        hit_valid = 1'b0;
        hit_row   = '0;
        hit_col   = '0;
        #12;
        checkOutput("reset_mask",  64'(invaders),  64'd0);
        checkOutput("reset_x",     64'(invX),      64'd40);
        checkOutput("reset_y",     64'(invY),      64'd48);
        checkOutput("reset_count", 64'(alive),     64'd0);
        checkOutput("reset_clear", 64'(waveClear), 64'd0);
        checkOutput("reset_land",  64'(landed),    64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        cycle();

        $display("[TB] wave start and first step");
        start = 1'b1;
        cycle();
        start = 1'b0;
        checkOutput("start_mask",  64'(invaders), 64'(ALL_ONES));
        checkOutput("start_count", 64'(alive),    64'd55);
        applyFrames(15);
        checkOutput("frame15_x", 64'(invX), 64'd40);
        applyFrames(1);
        checkOutput("step1_x", 64'(invX), 64'd44);
        checkOutput("step1_y", 64'(invY), 64'd48);

        $display("[TB] full formation to right bound");
        applyStimulus(103);
        checkOutput("x456", 64'(invX), 64'd456);
        applyStimulus(1);
        checkOutput("x460", 64'(invX), 64'd460);
        applyStimulus(1);
        checkOutput("descend_x", 64'(invX), 64'd460);
        checkOutput("descend_y", 64'(invY), 64'd56);
        applyStimulus(1);
        checkOutput("left_x", 64'(invX), 64'd456);

        $display("[TB] hits");
        expMask = ALL_ONES;
        expMask[25] = 1'b0;
        applyHit(2, 3);
        checkOutput("hit25_mask",  64'(invaders), 64'(expMask));
        checkOutput("hit25_count", 64'(alive),    64'd54);
        applyHit(2, 3);
        checkOutput("rehit_mask",  64'(invaders), 64'(expMask));
        checkOutput("rehit_count", 64'(alive),    64'd54);
        applyHit(5, 0);
        checkOutput("row5_count", 64'(alive), 64'd54);
        applyHit(0, 11);
        checkOutput("col11_count", 64'(alive), 64'd54);
        checkOutput("col11_mask",  64'(invaders), 64'(expMask));

        for (int r = 0; r < 5; r++) begin
            applyHit(r, 10);
            expMask[r * 11 + 10] = 1'b0;
        end
        checkOutput("col10_mask",  64'(invaders), 64'(expMask));
        checkOutput("col10_count", 64'(alive),    64'd49);

        $display("[TB] narrower formation");
        applyStimulus(111);
        checkOutput("x12", 64'(invX), 64'd12);
        applyStimulus(1);
        checkOutput("x8", 64'(invX), 64'd8);
        applyStimulus(1);
        checkOutput("ldesc_x", 64'(invX), 64'd8);
        checkOutput("ldesc_y", 64'(invY), 64'd64);
        applyStimulus(116);
        checkOutput("x472", 64'(invX), 64'd472);
        applyStimulus(1);
        checkOutput("x476", 64'(invX), 64'd476);
        applyStimulus(1);
        checkOutput("rdesc_x", 64'(invX), 64'd476);
        checkOutput("rdesc_y", 64'(invY), 64'd72);

        $display("[TB] clear the wave");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 11; c++) begin
                if (!(r == 4 && c == 9)) applyHit(r, c);
            end
        end
        checkOutput("last_count", 64'(alive),     64'd1);
        checkOutput("last_mask",  64'(invaders),  64'(55'd1 << 53));
        checkOutput("pre_clear",  64'(waveClear), 64'd0);
        applyHit(4, 9);
        checkOutput("clear_pulse", 64'(waveClear), 64'd1);
        checkOutput("clear_count", 64'(alive),     64'd0);
        checkOutput("clear_mask",  64'(invaders),  64'd0);
        cycle();
        checkOutput("clear_drop", 64'(waveClear), 64'd0);
        applyFrames(40);
        checkOutput("frozen_x",    64'(invX),      64'd476);
        checkOutput("frozen_y",    64'(invY),      64'd72);
        checkOutput("frozen_land", 64'(landed),    64'd0);
        checkOutput("frozen_wc",   64'(waveClear), 64'd0);

        $display("[TB] restart and asynchronous reset");
        start = 1'b1;
        cycle();
        start = 1'b0;
        checkOutput("restart_mask", 64'(invaders), 64'(ALL_ONES));
        checkOutput("restart_x",    64'(invX),     64'd40);
        checkOutput("restart_y",    64'(invY),     64'd48);
        applyStimulus(2);
        checkOutput("restart_x48", 64'(invX), 64'd48);
        applyFrames(5);
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        checkOutput("arst_mask",  64'(invaders), 64'd0);
        checkOutput("arst_x",     64'(invX),     64'd40);
        checkOutput("arst_y",     64'(invY),     64'd48);
        checkOutput("arst_count", 64'(alive),    64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        cycle();

        $display("[TB] landing");
        start2 = 1'b1;
        cycle();
        start2 = 1'b0;
        checkOutput("land_start_y", 64'(invY2),   64'd424);
        checkOutput("land_start_l", 64'(landed2), 64'd0);
        applyStimulus(1);
        checkOutput("land_x",   64'(invX2),   64'd460);
        checkOutput("land_y",   64'(invY2),   64'd432);
        checkOutput("land_lvl", 64'(landed2), 64'd1);
        applyStimulus(1);
        checkOutput("land_hold_y", 64'(invY2),   64'd432);
        checkOutput("land_hold_l", 64'(landed2), 64'd1);
        checkOutput("idle_mask",   64'(invaders), 64'd0);
        checkOutput("idle_x",      64'(invX),     64'd40);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
